// File: rtl/gpu_def.sv
// Shared scheduler/core dispatch definitions: FSM encoding, fence codes and
// header field geometry used by the task receive path.
package gpu_def;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FENCE_NONE = 2'd0,
    FENCE_ACQ  = 2'd1,
    FENCE_REL  = 2'd2
  } fence_e;

  localparam int FRAME_WORDS = 16;
  localparam int MASK_W      = 16;
  localparam int IF_NUM_W    = 6;
  localparam int FENCE_W     = 2;
  localparam int TOTAL_W     = 10;

  // Header decode positions inside the packed dispatch word
  localparam int IF_NUM_LSB  = 0;
  localparam int IF_NUM_MSB  = 5;
  localparam int FENCE_LSB   = 6;
  localparam int FENCE_MSB   = 7;

endpackage

// File: rtl/instr_buf.sv
// Local instruction buffer: one write port, one registered read port.
// A same-cycle read and write of one address returns the previous contents.
module instr_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  assign rdata_d = mem[raddr];
  assign rdata   = rdata_q;

  // Array contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

endmodule

// File: rtl/core_task_receiver.sv
// Per-core receiver for scheduler task dispatch: filters headers on the exec
// mask, pulls the instruction frames into the local buffer, then starts the core.
module core_task_receiver
  import gpu_def::*;
#(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = 16,
  parameter int INSTR_SIZE  = 16,
  parameter int FRAME_WORDS = gpu_def::FRAME_WORDS,
  parameter int IMEM_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          task_valid,
  input  logic [CORE_NUM-1:0]           task_exec_mask,
  input  logic [CORE_NUM-1:0]           task_init_r0,
  input  logic [INSTR_SIZE-1:0]         task_r0_data,
  input  logic [5:0]                    task_if_num,
  input  logic [1:0]                    task_fence,
  output logic                          core_reading,
  input  logic                          instr_valid,
  input  logic [INSTR_SIZE-1:0]         instr_data,
  output logic                          core_ready,
  output logic                          exec_start,
  input  logic                          exec_done,
  output logic [1:0]                    fence_q,
  output logic                          r0_init_valid,
  output logic [INSTR_SIZE-1:0]         r0_init_data,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_raddr,
  output logic [INSTR_SIZE-1:0]         imem_rdata,
  output logic                          err_busy,
  output logic                          err_overflow
);

  localparam int AW = $clog2(IMEM_DEPTH);

  state_e                state_q, state_d;
  logic [TOTAL_W-1:0]    total_q, total_d;
  logic [TOTAL_W-1:0]    req_cnt_q, req_cnt_d;
  logic [TOTAL_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [1:0]            fence_d;
  logic                  exec_start_q, exec_start_d;
  logic                  r0_init_valid_q, r0_init_valid_d;
  logic [INSTR_SIZE-1:0] r0_init_data_q, r0_init_data_d;
  logic                  err_busy_q, err_busy_d;
  logic                  err_overflow_q, err_overflow_d;

  logic                  selected;
  logic                  in_range;
  logic                  mem_we;
  logic [TOTAL_W-1:0]    hdr_total;
  logic                  unused_mask_bits;

  assign selected  = task_valid && task_exec_mask[CORE_ID];
  assign hdr_total = TOTAL_W'(task_if_num) * TOTAL_W'(FRAME_WORDS);
  assign in_range  = {{(32-TOTAL_W){1'b0}}, wr_cnt_q} < IMEM_DEPTH;
  assign unused_mask_bits = ^{task_exec_mask, task_init_r0};

  assign core_ready    = (state_q == ST_IDLE);
  assign core_reading  = (state_q == ST_LOAD) && (req_cnt_q < total_q);
  assign exec_start    = exec_start_q;
  assign r0_init_valid = r0_init_valid_q;
  assign r0_init_data  = r0_init_data_q;
  assign err_busy      = err_busy_q;
  assign err_overflow  = err_overflow_q;

  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    req_cnt_d       = req_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    fence_d         = fence_q;
    exec_start_d    = 1'b0;
    r0_init_valid_d = 1'b0;
    r0_init_data_d  = r0_init_data_q;
    err_busy_d      = err_busy_q;
    err_overflow_d  = err_overflow_q;
    mem_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (selected) begin
          fence_d   = task_fence;
          total_d   = hdr_total;
          req_cnt_d = '0;
          wr_cnt_d  = '0;
          if (task_init_r0[CORE_ID]) begin
            r0_init_valid_d = 1'b1;
            r0_init_data_d  = task_r0_data;
          end
          // An empty task is acknowledged but never started
          if (hdr_total != '0) state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (selected) err_busy_d = 1'b1;
        if (core_reading) req_cnt_d = req_cnt_q + TOTAL_W'(1);
        if (instr_valid && (wr_cnt_q < total_q)) begin
          wr_cnt_d = wr_cnt_q + TOTAL_W'(1);
          // Words past the buffer are counted but not stored
          if (in_range) mem_we = 1'b1;
          else          err_overflow_d = 1'b1;
          if (wr_cnt_q == total_q - TOTAL_W'(1)) begin
            state_d      = ST_EXEC;
            exec_start_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (selected)  err_busy_d = 1'b1;
        if (exec_done) state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      total_q         <= '0;
      req_cnt_q       <= '0;
      wr_cnt_q        <= '0;
      fence_q         <= '0;
      exec_start_q    <= 1'b0;
      r0_init_valid_q <= 1'b0;
      r0_init_data_q  <= '0;
      err_busy_q      <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      req_cnt_q       <= req_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      fence_q         <= fence_d;
      exec_start_q    <= exec_start_d;
      r0_init_valid_q <= r0_init_valid_d;
      r0_init_data_q  <= r0_init_data_d;
      err_busy_q      <= err_busy_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  instr_buf #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_SIZE)
  ) u_instr_buf (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (instr_data),
    .raddr (imem_raddr),
    .rdata (imem_rdata)
  );

endmodule

// File: tb/tb_core_task_receiver.sv
// Bench for core_task_receiver: a 256-deep core and a 16-deep core share all
// inputs; stored words are queued as they are sent and popped on readback.
module tb_core_task_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        task_valid;
  logic [15:0] task_exec_mask, task_init_r0, task_r0_data;
  logic [5:0]  task_if_num;
  logic [1:0]  task_fence;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        exec_done;
  logic [7:0]  raddr;

  logic        core_reading_a, core_ready_a, exec_start_a, r0_init_valid_a;
  logic        err_busy_a, err_overflow_a;
  logic [1:0]  fence_q_a;
  logic [15:0] r0_init_data_a, imem_rdata_a;
  logic        core_reading_b, core_ready_b, exec_start_b, r0_init_valid_b;
  logic        err_busy_b, err_overflow_b;
  logic [1:0]  fence_q_b;
  logic [15:0] r0_init_data_b, imem_rdata_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  int          res_rd_cnt, res_start_a, res_start_b, res_r0_cyc;
  logic [15:0] res_r0_data;

  always #5 clk = ~clk;

  core_task_receiver #(.CORE_ID(3), .CORE_NUM(16), .INSTR_SIZE(16),
                       .FRAME_WORDS(16), .IMEM_DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .task_valid(task_valid),
    .task_exec_mask(task_exec_mask), .task_init_r0(task_init_r0),
    .task_r0_data(task_r0_data), .task_if_num(task_if_num), .task_fence(task_fence),
    .core_reading(core_reading_a), .instr_valid(instr_valid), .instr_data(instr_data),
    .core_ready(core_ready_a), .exec_start(exec_start_a), .exec_done(exec_done),
    .fence_q(fence_q_a), .r0_init_valid(r0_init_valid_a), .r0_init_data(r0_init_data_a),
    .imem_raddr(raddr), .imem_rdata(imem_rdata_a),
    .err_busy(err_busy_a), .err_overflow(err_overflow_a));

  core_task_receiver #(.CORE_ID(3), .CORE_NUM(16), .INSTR_SIZE(16),
                       .FRAME_WORDS(16), .IMEM_DEPTH(16)) dut_b (
    .clk(clk), .reset(reset), .task_valid(task_valid),
    .task_exec_mask(task_exec_mask), .task_init_r0(task_init_r0),
    .task_r0_data(task_r0_data), .task_if_num(task_if_num), .task_fence(task_fence),
    .core_reading(core_reading_b), .instr_valid(instr_valid), .instr_data(instr_data),
    .core_ready(core_ready_b), .exec_start(exec_start_b), .exec_done(exec_done),
    .fence_q(fence_q_b), .r0_init_valid(r0_init_valid_b), .r0_init_data(r0_init_data_b),
    .imem_raddr(raddr[3:0]), .imem_rdata(imem_rdata_b),
    .err_busy(err_busy_b), .err_overflow(err_overflow_b));

  // Dispatch a selected header at cycle T, then act as the instruction source:
  // each request is answered one cycle later unless a gap is being inserted.
  task automatic do_load(input logic [5:0] ifn, input logic [15:0] base,
                         input logic [15:0] r0, input logic [1:0] fence,
                         input int gap_at, input int gap_len,
                         input int abort_at, input int b_lim);
    int  pending, sent, gap_left, c;
    bit  done, gap_used;
    qa.delete();
    qb.delete();
    res_rd_cnt = 0; res_start_a = -1; res_start_b = -1; res_r0_cyc = -1;
    res_r0_data = '0;
    @(negedge clk);
    task_valid = 1'b1; task_exec_mask = 16'h0008; task_init_r0 = 16'h0008;
    task_r0_data = r0; task_if_num = ifn; task_fence = fence;
    @(posedge clk);
    pending = 0; sent = 0; gap_left = 0; c = 0; done = 1'b0; gap_used = 1'b0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      task_valid = 1'b0;
      if (r0_init_valid_a && res_r0_cyc < 0) begin
        res_r0_cyc = c; res_r0_data = r0_init_data_a;
      end
      if (exec_start_a && res_start_a < 0) res_start_a = c;
      if (exec_start_b && res_start_b < 0) res_start_b = c;
      if (res_start_a >= 0 && res_start_b >= 0) done = 1'b1;
      if (abort_at >= 0 && sent == abort_at) done = 1'b1;
      if (gap_at >= 0 && sent == gap_at && !gap_used) begin
        gap_left = gap_len; gap_used = 1'b1;
      end
      instr_valid = 1'b0;
      if (!done) begin
        if (gap_left > 0) gap_left--;
        else if (pending > 0) begin
          instr_valid = 1'b1;
          instr_data  = base + 16'(sent);
          qa.push_back(base + 16'(sent));
          if (sent < b_lim) qb.push_back(base + 16'(sent));
          sent++;
          pending--;
        end
        if (core_reading_a) begin
          pending++;
          res_rd_cnt++;
        end
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic read_back(input bit use_b, input int n);
    logic [15:0] exp_w, got_w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      raddr = 8'(i);
      @(negedge clk);
      got_w = use_b ? imem_rdata_b : imem_rdata_a;
      exp_w = 16'hxxxx;
      if (use_b && qb.size() > 0) exp_w = qb.pop_front();
      else if (!use_b && qa.size() > 0) exp_w = qa.pop_front();
      checks++;
      if (got_w !== exp_w) begin
        failures++;
        $display("FAIL imem_%s[%0d] got=%h expected=%h", use_b ? "b" : "a", i, got_w, exp_w);
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; task_valid = 1'b0; task_exec_mask = '0; task_init_r0 = '0;
    task_r0_data = '0; task_if_num = '0; task_fence = '0; instr_valid = 1'b0;
    instr_data = '0; exec_done = 1'b0; raddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (core_ready_a !== 1'b1) begin failures++; $display("FAIL rst_core_ready got=%b expected=1", core_ready_a); end
    checks++; if (core_reading_a !== 1'b0) begin failures++; $display("FAIL rst_core_reading got=%b expected=0", core_reading_a); end
    checks++; if (exec_start_a !== 1'b0) begin failures++; $display("FAIL rst_exec_start got=%b expected=0", exec_start_a); end
    checks++; if (r0_init_valid_a !== 1'b0 || r0_init_data_a !== 16'h0) begin failures++; $display("FAIL rst_r0 got=%b/%h expected=0/0000", r0_init_valid_a, r0_init_data_a); end
    checks++; if (fence_q_a !== 2'd0) begin failures++; $display("FAIL rst_fence got=%0d expected=0", fence_q_a); end
    checks++; if (imem_rdata_a !== 16'h0) begin failures++; $display("FAIL rst_imem_rdata got=%h expected=0000", imem_rdata_a); end
    checks++; if (err_busy_a !== 1'b0 || err_overflow_a !== 1'b0) begin failures++; $display("FAIL rst_err got=%b%b expected=00", err_busy_a, err_overflow_a); end
  endtask

  task automatic test_single_frame();
    do_load(6'd1, 16'h1000, 16'hBEEF, 2'd2, -1, 0, -1, 0);
    checks++; if (res_r0_cyc != 1) begin failures++; $display("FAIL r0_cycle got=%0d expected=1", res_r0_cyc); end
    checks++; if (res_r0_data !== 16'hBEEF) begin failures++; $display("FAIL r0_data got=%h expected=beef", res_r0_data); end
    checks++; if (res_rd_cnt != 16) begin failures++; $display("FAIL single_reading_cycles got=%0d expected=16", res_rd_cnt); end
    checks++; if (res_start_a != 18) begin failures++; $display("FAIL single_exec_start got=%0d expected=18", res_start_a); end
    checks++; if (fence_q_a !== 2'd2) begin failures++; $display("FAIL single_fence got=%0d expected=2", fence_q_a); end
    checks++; if (err_overflow_b !== 1'b0) begin failures++; $display("FAIL depth16_exact_fit_overflow got=%b expected=0", err_overflow_b); end
    read_back(1'b0, 16);
    checks++; if (core_ready_a !== 1'b0) begin failures++; $display("FAIL exec_core_ready got=%b expected=0", core_ready_a); end
    pulse_done();
    checks++; if (core_ready_a !== 1'b1) begin failures++; $display("FAIL done_core_ready got=%b expected=1", core_ready_a); end
  endtask

  task automatic test_mask_clear();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      task_valid = 1'b1; task_exec_mask = 16'h0004; task_init_r0 = 16'h0008;
      task_if_num = 6'd1; task_fence = 2'd1;
      @(negedge clk);
      task_valid = 1'b0;
      checks++;
      if (core_reading_a !== 1'b0 || core_ready_a !== 1'b1 || r0_init_valid_a !== 1'b0) begin
        failures++;
        $display("FAIL mask_clear[%0d] reading=%b ready=%b r0v=%b expected=0/1/0", i, core_reading_a, core_ready_a, r0_init_valid_a);
      end
    end
  endtask

  task automatic test_zero_frames();
    @(negedge clk);
    task_valid = 1'b1; task_exec_mask = 16'h0008; task_init_r0 = 16'h0008;
    task_r0_data = 16'h1234; task_if_num = 6'd0; task_fence = 2'd1;
    @(negedge clk);
    task_valid = 1'b0;
    checks++; if (r0_init_valid_a !== 1'b1 || r0_init_data_a !== 16'h1234) begin failures++; $display("FAIL zero_r0 got=%b/%h expected=1/1234", r0_init_valid_a, r0_init_data_a); end
    checks++; if (fence_q_a !== 2'd1) begin failures++; $display("FAIL zero_fence got=%0d expected=1", fence_q_a); end
    @(negedge clk);
    checks++; if (core_ready_a !== 1'b1 || core_reading_a !== 1'b0 || r0_init_valid_a !== 1'b0) begin failures++; $display("FAIL zero_idle ready=%b reading=%b r0v=%b expected=1/0/0", core_ready_a, core_reading_a, r0_init_valid_a); end
  endtask

  task automatic test_gaps();
    do_load(6'd2, 16'h2000, 16'h0000, 2'd0, 8, 3, -1, 16);
    checks++; if (res_rd_cnt != 32) begin failures++; $display("FAIL gap_reading_cycles got=%0d expected=32", res_rd_cnt); end
    checks++; if (res_start_a != 37) begin failures++; $display("FAIL gap_exec_start got=%0d expected=37", res_start_a); end
    checks++; if (err_overflow_a !== 1'b0) begin failures++; $display("FAIL gap_overflow_a got=%b expected=0", err_overflow_a); end
    read_back(1'b0, 32);
  endtask

  task automatic test_overflow();
    checks++; if (err_overflow_b !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b expected=1", err_overflow_b); end
    checks++; if (res_start_b != 37) begin failures++; $display("FAIL ovf_exec_start got=%0d expected=37", res_start_b); end
    read_back(1'b1, 16);
    pulse_done();
    checks++; if (core_ready_b !== 1'b1 || err_overflow_b !== 1'b1) begin failures++; $display("FAIL ovf_after_done ready=%b ovf=%b expected=1/1", core_ready_b, err_overflow_b); end
  endtask

  task automatic test_busy();
    do_load(6'd1, 16'h3000, 16'h0000, 2'd2, -1, 0, -1, 0);
    checks++; if (err_busy_a !== 1'b0) begin failures++; $display("FAIL busy_before got=%b expected=0", err_busy_a); end
    @(negedge clk);
    task_valid = 1'b1; task_exec_mask = 16'h0008; task_init_r0 = 16'h0000;
    task_if_num = 6'd1; task_fence = 2'd1;
    @(negedge clk);
    task_valid = 1'b0;
    checks++; if (err_busy_a !== 1'b1) begin failures++; $display("FAIL busy_flag got=%b expected=1", err_busy_a); end
    checks++; if (fence_q_a !== 2'd2 || core_ready_a !== 1'b0) begin failures++; $display("FAIL busy_ignored fence=%0d ready=%b expected=2/0", fence_q_a, core_ready_a); end
    task_valid = 1'b1; task_fence = 2'd3; exec_done = 1'b1;
    @(negedge clk);
    task_valid = 1'b0; exec_done = 1'b0;
    checks++; if (core_ready_a !== 1'b1 || fence_q_a !== 2'd2) begin failures++; $display("FAIL done_with_header ready=%b fence=%0d expected=1/2", core_ready_a, fence_q_a); end
    @(negedge clk);
    checks++; if (core_reading_a !== 1'b0 || core_ready_a !== 1'b1) begin failures++; $display("FAIL done_with_header_idle reading=%b ready=%b expected=0/1", core_reading_a, core_ready_a); end
  endtask

  task automatic test_reset_mid_load();
    bit saw_start, saw_read;
    do_load(6'd1, 16'h4000, 16'h0000, 2'd1, -1, 0, 5, 0);
    qa.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (core_ready_a !== 1'b1 || core_reading_a !== 1'b0) begin failures++; $display("FAIL midload_reset ready=%b reading=%b expected=1/0", core_ready_a, core_reading_a); end
    checks++; if (err_busy_a !== 1'b0) begin failures++; $display("FAIL midload_reset_busy got=%b expected=0", err_busy_a); end
    saw_start = 1'b0; saw_read = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (exec_start_a) saw_start = 1'b1;
      if (core_reading_a) saw_read = 1'b1;
    end
    checks++; if (saw_start || saw_read) begin failures++; $display("FAIL midload_quiet start=%b reading=%b expected=0/0", saw_start, saw_read); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_mask_clear();
    test_zero_frames();
    test_gaps();
    test_overflow();
    test_busy();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
